// File: rtl/rom3_fetch_ctrl.sv
// Burst fetch controller: issues sequential ROM reads under FIFO credit and streams words out.
// Optional out_last marker on the final word of a command when ROM3_FETCH_LAST_EN is defined.
module rom3_fetch_ctrl #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 256,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [15:0]       cmd_len,
    input  logic [3:0]        cmd_sel,
    output logic              rom_ena,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [3:0]        rom_s,
    input  logic [DATA_W-1:0] rom_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
`ifdef ROM3_FETCH_LAST_EN
    output logic              out_last,
`endif
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       remain_q, remain_d;
    logic [3:0]        sel_q, sel_d;
    logic [RD_LAT-1:0] tag_q, tag_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic              done_q, done_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

    logic accept, issue, push, pop, credit, drained;

    assign cmd_ready = (state_q == S_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign rom_ena   = (state_q != S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign rom_addr  = addr_q;
    assign rom_s     = sel_q;
    assign done      = done_q;

    // Credit counts reads already in flight so the FIFO can never overflow.
    assign credit  = ({1'b0, inflight_q} + {1'b0, count_q}) < (CNT_W + 1)'(FIFO_DEPTH);
    assign issue   = (state_q == S_ISSUE) && credit;
    assign push    = tag_q[RD_LAT-1];
    assign pop     = out_valid && out_ready;
    assign drained = (inflight_q == '0) && (count_q == '0);

    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        sel_d    = sel_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (cmd_len == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d   = cmd_base;
                        remain_d = cmd_len;
                        sel_d    = cmd_sel;
                        state_d  = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (issue) begin
                    addr_d   = addr_q + ADDR_W'(1);
                    remain_d = remain_q - 16'd1;
                    if (remain_q == 16'd1) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (drained) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        tag_d    = '0;
        tag_d[0] = issue;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
        inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(push);
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            sel_q      <= '0;
            tag_q      <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            sel_q      <= sel_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            done_q     <= done_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // Storage needs no reset: the count gates visibility of every entry.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= rom_data;
    end

`ifdef ROM3_FETCH_LAST_EN
    logic [RD_LAT-1:0]     ltag_q, ltag_d;
    logic [FIFO_DEPTH-1:0] lmem_q;

    always_comb begin
        ltag_d    = '0;
        ltag_d[0] = issue && (remain_q == 16'd1);
        for (int i = 1; i < RD_LAT; i++) begin
            ltag_d[i] = ltag_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ltag_q <= '0;
        end else begin
            ltag_q <= ltag_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) lmem_q[wr_ptr_q] <= ltag_q[RD_LAT-1];
    end

    assign out_last = out_valid && lmem_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_rom3_fetch_ctrl.sv
// Directed bench for rom3_fetch_ctrl with a behavioural RD_LAT=2 ROM model.
// Define ROM3_FETCH_LAST_EN to also exercise the out_last marker.
module tb_rom3_fetch_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [15:0]  cmd_base;
    logic [15:0]  cmd_len;
    logic [3:0]   cmd_sel;
    logic         rom_ena;
    logic [15:0]  rom_addr;
    logic [3:0]   rom_s;
    logic [255:0] rom_data;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_data;
    logic         busy;
    logic         done;
`ifdef ROM3_FETCH_LAST_EN
    logic         out_last;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    rom3_fetch_ctrl #(.ADDR_W(16), .DATA_W(256), .RD_LAT(2), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_base  (cmd_base),
        .cmd_len   (cmd_len),
        .cmd_sel   (cmd_sel),
        .rom_ena   (rom_ena),
        .rom_addr  (rom_addr),
        .rom_s     (rom_s),
        .rom_data  (rom_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef ROM3_FETCH_LAST_EN
        .out_last  (out_last),
`endif
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] rom_word(input logic [15:0] a, input logic [3:0] s);
        return {s, 220'd0, 16'hBEEF, a};
    endfunction

    // Two-stage ROM pipeline that advances only while enabled.
    logic [255:0] rp1, rp2;
    always @(posedge clk) begin
        if (rom_ena) begin
            rp1 <= rom_word(rom_addr, rom_s);
            rp2 <= rp1;
        end
    end
    assign rom_data = rp2;

    logic [255:0] words[$];
    int           wcyc[$];
    logic [15:0]  addr_log[$];
    logic         lasts[$];
    int cyc = 0, done_cnt = 0, ena_cnt = 0, ov_cnt = 0, max_occ = 0, busy_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                words.push_back(out_data);
                wcyc.push_back(cyc);
`ifdef ROM3_FETCH_LAST_EN
                lasts.push_back(out_last);
`endif
            end
            if (done) done_cnt++;
            if (done && busy) busy_err++;
            if (out_valid) ov_cnt++;
            if (rom_ena) begin
                ena_cnt++;
                if (addr_log.size() == 0 || addr_log[$] != rom_addr) addr_log.push_back(rom_addr);
            end
            if (int'(dut.inflight_q) + int'(dut.count_q) > max_occ)
                max_occ = int'(dut.inflight_q) + int'(dut.count_q);
        end
    end

    task automatic send_cmd(input logic [15:0] base, input logic [15:0] len, input logic [3:0] sel);
        int n = 0;
        while (!cmd_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        n_tests++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cmd_ready_wait: got %b expected 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_base  = base;
        cmd_len   = len;
        cmd_sel   = sel;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int start, input int budget, input string name);
        int n = 0;
        while (done_cnt == start && n < budget) begin
            @(posedge clk); #1; n++;
        end
        n_tests++;
        if (done_cnt == start) begin
            n_fail++;
            $display("FAIL %s_timeout: done count %0d expected > %0d", name, done_cnt, start);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_base = '0; cmd_len = '0; cmd_sel = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_tests++; if (done !== 1'b0)      begin n_fail++; $display("FAIL rst_done: got %b expected 0", done); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        n_tests++; if (rom_ena !== 1'b0)   begin n_fail++; $display("FAIL rst_rom_ena: got %b expected 0", rom_ena); end
        n_tests++; if (rom_addr !== 16'h0) begin n_fail++; $display("FAIL rst_rom_addr: got %h expected 0000", rom_addr); end
        n_tests++; if (rom_s !== 4'h0)     begin n_fail++; $display("FAIL rst_rom_s: got %h expected 0", rom_s); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_basic();
        int w0 = words.size();
        int a0 = addr_log.size();
        int d0 = done_cnt;
        int lat = 0;
        out_ready = 1'b1;
        send_cmd(16'h0010, 16'd4, 4'd1);
        n_tests++; if (rom_s !== 4'd1) begin n_fail++; $display("FAIL basic_rom_s: got %h expected 1", rom_s); end
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        n_tests++; if (lat != 3) begin n_fail++; $display("FAIL basic_latency: got %0d expected 3", lat); end
        wait_done(d0, 50, "basic");
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (words.size() - w0 != 4) begin
            n_fail++; $display("FAIL basic_count: got %0d expected 4", words.size() - w0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (words[w0+i] !== rom_word(16'(16'h0010 + i), 4'd1)) begin
                    n_fail++; $display("FAIL basic_word%0d: got %h expected %h", i, words[w0+i][15:0], 16'(16'h0010 + i));
                end
            end
            n_tests++;
            if (wcyc[w0+3] - wcyc[w0] != 3) begin
                n_fail++; $display("FAIL basic_throughput: span %0d expected 3", wcyc[w0+3] - wcyc[w0]);
            end
        end
        n_tests++;
        if (addr_log.size() - a0 < 4) begin
            n_fail++; $display("FAIL basic_addr_count: got %0d expected >= 4", addr_log.size() - a0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (addr_log[a0+i] !== 16'(16'h0010 + i)) begin
                    n_fail++; $display("FAIL basic_addr%0d: got %h expected %h", i, addr_log[a0+i], 16'(16'h0010 + i));
                end
            end
        end
        n_tests++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL basic_done_once: got %0d expected 1", done_cnt - d0); end
        n_tests++; if (busy_err != 0) begin n_fail++; $display("FAIL basic_busy_drop: got %0d overlaps expected 0", busy_err); end
    endtask

    task automatic test_zero_len();
        int d0 = done_cnt;
        int e0 = ena_cnt;
        int v0 = ov_cnt;
        send_cmd(16'h0050, 16'd0, 4'd2);
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done_pulse: got %b expected 1", done); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %b expected 0", busy); end
        @(posedge clk); #1;
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_end: got %b expected 0", done); end
        repeat (5) @(posedge clk);
        #1;
        n_tests++; if (ena_cnt != e0) begin n_fail++; $display("FAIL zero_rom_ena: got %0d cycles expected 0", ena_cnt - e0); end
        n_tests++; if (ov_cnt != v0) begin n_fail++; $display("FAIL zero_out_valid: got %0d cycles expected 0", ov_cnt - v0); end
        n_tests++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL zero_done_once: got %0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_wrap();
        int w0 = words.size();
        int a0 = addr_log.size();
        int d0 = done_cnt;
        logic [15:0] exp_a [3];
        exp_a[0] = 16'hFFFE; exp_a[1] = 16'hFFFF; exp_a[2] = 16'h0000;
        out_ready = 1'b1;
        send_cmd(16'hFFFE, 16'd3, 4'd3);
        wait_done(d0, 50, "wrap");
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (words.size() - w0 != 3) begin
            n_fail++; $display("FAIL wrap_count: got %0d expected 3", words.size() - w0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (words[w0+i] !== rom_word(exp_a[i], 4'd3)) begin
                    n_fail++; $display("FAIL wrap_word%0d: got %h expected %h", i, words[w0+i][15:0], exp_a[i]);
                end
            end
        end
        n_tests++;
        if (addr_log.size() - a0 < 3) begin
            n_fail++; $display("FAIL wrap_addr_count: got %0d expected >= 3", addr_log.size() - a0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (addr_log[a0+i] !== exp_a[i]) begin
                    n_fail++; $display("FAIL wrap_addr%0d: got %h expected %h", i, addr_log[a0+i], exp_a[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int w0 = words.size();
        int d0 = done_cnt;
        int k = 0;
        int bad = -1;
        out_ready = 1'b0;
        send_cmd(16'h0200, 16'd16, 4'd5);
        repeat (20) @(posedge clk);
        #1;
        n_tests++; if (words.size() != w0) begin n_fail++; $display("FAIL bp_stalled: got %0d words expected 0", words.size() - w0); end
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held: got %b expected 1", out_valid); end
        while (done_cnt == d0 && k < 300) begin
            out_ready = (k % 3 != 0);
            @(posedge clk); #1; k++;
        end
        out_ready = 1'b1;
        n_tests++; if (done_cnt == d0) begin n_fail++; $display("FAIL bp_timeout: done count %0d expected > %0d", done_cnt, d0); end
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (words.size() - w0 != 16) begin
            n_fail++; $display("FAIL bp_count: got %0d expected 16", words.size() - w0);
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (bad < 0 && words[w0+i] !== rom_word(16'(16'h0200 + i), 4'd5)) bad = i;
            end
            n_tests++;
            if (bad >= 0) begin
                n_fail++; $display("FAIL bp_order: word %0d got %h expected %h", bad, words[w0+bad][15:0], 16'(16'h0200 + bad));
            end
        end
        n_tests++; if (max_occ > 4) begin n_fail++; $display("FAIL bp_credit: got occupancy %0d expected <= 4", max_occ); end
    endtask

    task automatic test_reset_mid();
        int w0;
        int d0;
        out_ready = 1'b1;
        send_cmd(16'h0300, 16'd8, 4'd6);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid: got %b expected 0", out_valid); end
        n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rmid_busy: got %b expected 0", busy); end
        n_tests++; if (rom_ena !== 1'b0)   begin n_fail++; $display("FAIL rmid_rom_ena: got %b expected 0", rom_ena); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        w0 = words.size();
        d0 = done_cnt;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_stale: got %b expected 0", out_valid); end
        send_cmd(16'h0100, 16'd2, 4'd0);
        wait_done(d0, 50, "rmid");
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (words.size() - w0 != 2) begin
            n_fail++; $display("FAIL rmid_count: got %0d expected 2", words.size() - w0);
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_tests++;
                if (words[w0+i] !== rom_word(16'(16'h0100 + i), 4'd0)) begin
                    n_fail++; $display("FAIL rmid_word%0d: got %h expected %h", i, words[w0+i][15:0], 16'(16'h0100 + i));
                end
            end
        end
    endtask

`ifdef ROM3_FETCH_LAST_EN
    task automatic test_last();
        int l0 = lasts.size();
        int d0 = done_cnt;
        logic exp_l [3];
        exp_l[0] = 1'b0; exp_l[1] = 1'b0; exp_l[2] = 1'b1;
        out_ready = 1'b1;
        send_cmd(16'h0020, 16'd3, 4'd7);
        wait_done(d0, 50, "last");
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (lasts.size() - l0 != 3) begin
            n_fail++; $display("FAIL last_count: got %0d expected 3", lasts.size() - l0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (lasts[l0+i] !== exp_l[i]) begin
                    n_fail++; $display("FAIL last_flag%0d: got %b expected %b", i, lasts[l0+i], exp_l[i]);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_wrap();
        test_backpressure();
        test_reset_mid();
`ifdef ROM3_FETCH_LAST_EN
        test_last();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
